// File: rtl/riscv_pkg.sv
// Shared RV32 encodings and pipeline-control types for the branch-resolve E stage.
// Immediate extraction helpers live here so any stage can decode the same formats.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } br_state_e;

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Six-way RV32 branch condition evaluator; reserved funct3 codes never take.
module branch_cmp
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        funct3,
  output logic              taken
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = signed'(a);
  assign b_s = signed'(b);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (a == b);
      F3_BNE:  taken = (a != b);
      F3_BLT:  taken = (a_s < b_s);
      F3_BGE:  taken = (a_s >= b_s);
      F3_BLTU: taken = (a < b);
      F3_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_cycle.sv
// E-stage branch/jump resolution: registers D, resolves redirects, squashes one
// wrong-path slot per redirect, and halts with a sticky trap on misaligned targets.
module branch_resolve_cycle
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        ValidE,
  output logic [31:0] InstrE,
  output logic [31:0] PCE,
  output logic [31:0] LinkE,
  output logic        TrapE,
  output logic [15:0] BranchCountE
);

  logic [31:0] instr_q, pc_q, pc_plus4_q, rd1_q, rd2_q;
  logic        valid_q, valid_d;
  logic        trap_q, trap_d;
  logic [15:0] br_count_q, br_count_d;
  br_state_e   state_q, state_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_branch, is_jal, is_jalr, br_taken;
  logic        redirect_req, halt_req;
  logic [31:0] target;

  // ---- D -> E boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      valid_q    <= 1'b0;
      state_q    <= ST_RUN;
      trap_q     <= 1'b0;
      br_count_q <= '0;
    end else begin
      instr_q    <= InstrD;
      pc_q       <= PCD;
      pc_plus4_q <= PCPlus4D;
      rd1_q      <= RD1D;
      rd2_q      <= RD2D;
      valid_q    <= valid_d;
      state_q    <= state_d;
      trap_q     <= trap_d;
      br_count_q <= br_count_d;
    end
  end

  assign opcode    = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  branch_cmp #(.DATA_W(32)) u_cmp (
    .a      (rd1_q),
    .b      (rd2_q),
    .funct3 (funct3),
    .taken  (br_taken)
  );

  always_comb begin
    target = pc_plus4_q;
    if (is_branch && br_taken) target = pc_q + imm_b(instr_q);
    else if (is_jal)           target = pc_q + imm_j(instr_q);
    else if (is_jalr)          target = (rd1_q + imm_i(instr_q)) & 32'hFFFF_FFFE;
  end

  // A squashed slot or a non-RUN state can never redirect fetch.
  assign redirect_req = valid_q && (state_q == ST_RUN) &&
                        ((is_branch && br_taken) || is_jal || is_jalr);
  assign PCSrcE       = redirect_req && (target[1:0] == 2'b00);
  assign halt_req     = redirect_req && (target[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (PCSrcE)        state_d = ST_FLUSH;
        else if (halt_req) state_d = ST_HALT;
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase
  end

  // The slot arriving with the redirect is wrong-path: exactly one bubble.
  always_comb begin
    valid_d = 1'b1;
    if (PCSrcE || (state_d == ST_HALT)) valid_d = 1'b0;
  end

  always_comb begin
    trap_d     = trap_q | halt_req;
    br_count_d = br_count_q;
    if (PCSrcE && (br_count_q != 16'hFFFF)) br_count_d = br_count_q + 16'd1;
  end

  assign PCTargetE    = target;
  assign ValidE       = valid_q;
  assign InstrE       = instr_q;
  assign PCE          = pc_q;
  assign LinkE        = (valid_q && (is_jal || is_jalr)) ? pc_plus4_q : 32'h0;
  assign TrapE        = trap_q;
  assign BranchCountE = br_count_q;

endmodule

// File: tb/tb_branch_resolve_cycle.sv
// Directed self-checking bench for branch_resolve_cycle.
module tb_branch_resolve_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D;
  logic        PCSrcE, ValidE, TrapE;
  logic [31:0] PCTargetE, InstrE, PCE, LinkE;
  logic [15:0] BranchCountE;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BEQ_16   = 32'h0020_8863;
  localparam logic [31:0] BLT_8    = 32'h0020_C463;
  localparam logic [31:0] JAL_32   = 32'h0200_00EF;
  localparam logic [31:0] JALR_4   = 32'h0040_80E7;
  localparam logic [31:0] JALR_0   = 32'h0000_80E7;

  always #5 clk = ~clk;

  branch_resolve_cycle dut (
    .clk          (clk),
    .rst          (rst),
    .InstrD       (InstrD),
    .PCD          (PCD),
    .PCPlus4D     (PCPlus4D),
    .RD1D         (RD1D),
    .RD2D         (RD2D),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .ValidE       (ValidE),
    .InstrE       (InstrE),
    .PCE          (PCE),
    .LinkE        (LinkE),
    .TrapE        (TrapE),
    .BranchCountE (BranchCountE)
  );

  task drive(input logic [31:0] instr, input logic [31:0] pc,
             input logic [31:0] rd1, input logic [31:0] rd2);
    InstrD   = instr;
    PCD      = pc;
    PCPlus4D = pc + 32'd4;
    RD1D     = rd1;
    RD2D     = rd2;
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    rst = 1'b0;
    drive(NOP, 32'h0, 32'h0, 32'h0);
    #200;
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL reset_pcsrc got %b want 0", PCSrcE); end
    checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ValidE); end
    checks++; if (BranchCountE !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0", BranchCountE); end
    checks++; if (InstrE !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", InstrE, NOP); end
    checks++; if (PCTargetE !== 32'h0) begin errors++; $display("FAIL reset_target got %h want 0", PCTargetE); end
    checks++; if (TrapE !== 1'b0) begin errors++; $display("FAIL reset_trap got %b want 0", TrapE); end
    @(negedge clk);
    rst = 1'b1;
    drive(NOP, 32'h10, 32'h0, 32'h0);
    tick;
    checks++; if (ValidE !== 1'b1) begin errors++; $display("FAIL first_load_valid got %b want 1", ValidE); end
    checks++; if (PCE !== 32'h10) begin errors++; $display("FAIL first_load_pc got %h want 10", PCE); end
  endtask

  task test_beq_taken;
    drive(BEQ_16, 32'h100, 32'd5, 32'd5);
    tick;
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL beq_t_pcsrc got %b want 1", PCSrcE); end
    checks++; if (PCTargetE !== 32'h110) begin errors++; $display("FAIL beq_t_target got %h want 110", PCTargetE); end
    drive(NOP, 32'h104, 32'h0, 32'h0);
    tick;
    checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL beq_t_bubble got %b want 0", ValidE); end
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL beq_t_flush_pcsrc got %b want 0", PCSrcE); end
    checks++; if (BranchCountE !== 16'd1) begin errors++; $display("FAIL beq_t_count got %0d want 1", BranchCountE); end
    drive(NOP, 32'h110, 32'h0, 32'h0);
    tick;
    checks++; if (ValidE !== 1'b1) begin errors++; $display("FAIL beq_t_resume got %b want 1", ValidE); end
  endtask

  task test_beq_not_taken;
    drive(BEQ_16, 32'h100, 32'd5, 32'd6);
    tick;
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL beq_nt_pcsrc got %b want 0", PCSrcE); end
    checks++; if (PCTargetE !== 32'h104) begin errors++; $display("FAIL beq_nt_target got %h want 104", PCTargetE); end
    drive(NOP, 32'h104, 32'h0, 32'h0);
    tick;
    checks++; if (ValidE !== 1'b1) begin errors++; $display("FAIL beq_nt_nobubble got %b want 1", ValidE); end
    checks++; if (BranchCountE !== 16'd1) begin errors++; $display("FAIL beq_nt_count got %0d want 1", BranchCountE); end
  endtask

  task test_jalr;
    drive(JALR_4, 32'h40, 32'h201, 32'h0);
    tick;
    checks++; if (PCTargetE !== 32'h204) begin errors++; $display("FAIL jalr_target got %h want 204", PCTargetE); end
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL jalr_pcsrc got %b want 1", PCSrcE); end
    checks++; if (LinkE !== 32'h44) begin errors++; $display("FAIL jalr_link got %h want 44", LinkE); end
    drive(NOP, 32'h44, 32'h0, 32'h0);
    tick;
    checks++; if (BranchCountE !== 16'd2) begin errors++; $display("FAIL jalr_count got %0d want 2", BranchCountE); end
    drive(NOP, 32'h204, 32'h0, 32'h0);
    tick;
  endtask

  task test_back_to_back_squash;
    drive(BLT_8, 32'h200, 32'hFFFF_FFFF, 32'd1);
    tick;
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL blt_pcsrc got %b want 1", PCSrcE); end
    checks++; if (PCTargetE !== 32'h208) begin errors++; $display("FAIL blt_target got %h want 208", PCTargetE); end
    drive(JAL_32, 32'h204, 32'h0, 32'h0);
    tick;
    checks++; if (InstrE !== JAL_32) begin errors++; $display("FAIL sq_instr got %h want %h", InstrE, JAL_32); end
    checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL sq_valid got %b want 0", ValidE); end
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL sq_pcsrc got %b want 0", PCSrcE); end
    checks++; if (LinkE !== 32'h0) begin errors++; $display("FAIL sq_link got %h want 0", LinkE); end
    drive(NOP, 32'h208, 32'h0, 32'h0);
    tick;
    checks++; if (ValidE !== 1'b1) begin errors++; $display("FAIL sq_resume got %b want 1", ValidE); end
    checks++; if (BranchCountE !== 16'd3) begin errors++; $display("FAIL sq_count got %0d want 3", BranchCountE); end
  endtask

  task test_branch_table;
    logic [2:0]  f3_t  [6];
    logic [31:0] a_t   [6];
    logic [31:0] b_t   [6];
    logic        tk_t  [6];
    logic [31:0] instr;
    logic [15:0] exp_cnt;
    f3_t[0] = 3'b001; a_t[0] = 32'd5;        b_t[0] = 32'd6; tk_t[0] = 1'b1; // BNE
    f3_t[1] = 3'b100; a_t[1] = 32'hFFFFFFFF; b_t[1] = 32'd1; tk_t[1] = 1'b1; // BLT -1<1
    f3_t[2] = 3'b101; a_t[2] = 32'hFFFFFFFF; b_t[2] = 32'd1; tk_t[2] = 1'b0; // BGE
    f3_t[3] = 3'b110; a_t[3] = 32'hFFFFFFFF; b_t[3] = 32'd1; tk_t[3] = 1'b0; // BLTU
    f3_t[4] = 3'b111; a_t[4] = 32'hFFFFFFFF; b_t[4] = 32'd1; tk_t[4] = 1'b1; // BGEU
    f3_t[5] = 3'b010; a_t[5] = 32'd5;        b_t[5] = 32'd5; tk_t[5] = 1'b0; // reserved
    exp_cnt = 16'd3;
    for (int i = 0; i < 6; i++) begin
      instr = BEQ_16 | {17'b0, f3_t[i], 12'b0};
      drive(instr, 32'h100, a_t[i], b_t[i]);
      tick;
      checks++; if (PCSrcE !== tk_t[i]) begin errors++; $display("FAIL tbl%0d_pcsrc got %b want %b", i, PCSrcE, tk_t[i]); end
      checks++; if (PCTargetE !== (tk_t[i] ? 32'h110 : 32'h104)) begin errors++; $display("FAIL tbl%0d_target got %h want %h", i, PCTargetE, (tk_t[i] ? 32'h110 : 32'h104)); end
      if (tk_t[i]) exp_cnt = exp_cnt + 16'd1;
      drive(NOP, 32'h104, 32'h0, 32'h0);
      tick;
      checks++; if (ValidE !== !tk_t[i]) begin errors++; $display("FAIL tbl%0d_valid got %b want %b", i, ValidE, !tk_t[i]); end
      checks++; if (BranchCountE !== exp_cnt) begin errors++; $display("FAIL tbl%0d_count got %0d want %0d", i, BranchCountE, exp_cnt); end
      drive(NOP, 32'h108, 32'h0, 32'h0);
      tick;
    end
  endtask

  task test_trap;
    drive(JALR_0, 32'h300, 32'h202, 32'h0);
    tick;
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL trap_pcsrc got %b want 0", PCSrcE); end
    checks++; if (TrapE !== 1'b0) begin errors++; $display("FAIL trap_early got %b want 0", TrapE); end
    drive(NOP, 32'h304, 32'h0, 32'h0);
    tick;
    checks++; if (TrapE !== 1'b1) begin errors++; $display("FAIL trap_set got %b want 1", TrapE); end
    checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL trap_valid got %b want 0", ValidE); end
    drive(JAL_32, 32'h308, 32'h0, 32'h0);
    repeat (3) tick;
    checks++; if (TrapE !== 1'b1) begin errors++; $display("FAIL trap_hold got %b want 1", TrapE); end
    checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL trap_hold_valid got %b want 0", ValidE); end
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL trap_hold_pcsrc got %b want 0", PCSrcE); end
    checks++; if (BranchCountE !== 16'd6) begin errors++; $display("FAIL trap_count got %0d want 6", BranchCountE); end
    rst = 1'b0;
    #1;
    checks++; if (TrapE !== 1'b0) begin errors++; $display("FAIL trap_clear got %b want 0", TrapE); end
    checks++; if (BranchCountE !== 16'd0) begin errors++; $display("FAIL trap_rst_count got %0d want 0", BranchCountE); end
    checks++; if (InstrE !== NOP) begin errors++; $display("FAIL trap_rst_instr got %h want %h", InstrE, NOP); end
    @(negedge clk);
    rst = 1'b1;
    drive(BEQ_16, 32'h100, 32'd7, 32'd7);
    tick;
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL trap_exit_pcsrc got %b want 1", PCSrcE); end
  endtask

  task test_reset_mid_flush;
    drive(NOP, 32'h104, 32'h0, 32'h0);
    tick;
    checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL mf_in_flush got %b want 0", ValidE); end
    rst = 1'b0;
    #1;
    checks++; if (PCE !== 32'h0) begin errors++; $display("FAIL mf_pc got %h want 0", PCE); end
    checks++; if (BranchCountE !== 16'd0) begin errors++; $display("FAIL mf_count got %0d want 0", BranchCountE); end
    checks++; if (PCTargetE !== 32'h0) begin errors++; $display("FAIL mf_target got %h want 0", PCTargetE); end
    @(negedge clk);
    rst = 1'b1;
    drive(JAL_32, 32'h80, 32'h0, 32'h0);
    tick;
    checks++; if (ValidE !== 1'b1) begin errors++; $display("FAIL mf_run_valid got %b want 1", ValidE); end
    checks++; if (PCTargetE !== 32'hA0) begin errors++; $display("FAIL mf_jal_target got %h want a0", PCTargetE); end
    checks++; if (LinkE !== 32'h84) begin errors++; $display("FAIL mf_jal_link got %h want 84", LinkE); end
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL mf_jal_pcsrc got %b want 1", PCSrcE); end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_beq_not_taken();
    test_jalr();
    test_back_to_back_squash();
    test_branch_table();
    test_trap();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_cycle.md
BRANCH_RESOLVE_CYCLE -- requirements
Module: branch_resolve_cycle

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock.
REQ-002 SHALL have port: rst  input  1  asynchronous active-low reset; 0 = reset.
REQ-003 SHALL have port: InstrD  input  32  instruction from fetch stage.
REQ-004 SHALL have port: PCD  input  32  PC of InstrD.
REQ-005 SHALL have port: PCPlus4D  input  32  PCD+4 from fetch.
REQ-006 SHALL have port: RD1D, RD2D  input  32 each  rs1/rs2 operand values for InstrD.
REQ-007 SHALL have port: PCSrcE  output  1  redirect fetch; 1 = take PCTargetE.
REQ-008 SHALL have port: PCTargetE  output  32  redirect address to fetch.
REQ-009 SHALL have port: ValidE  output  1  E-stage instruction is live (not squashed).
REQ-010 SHALL have port: InstrE, PCE  output  32 each  registered instruction and PC.
REQ-011 SHALL have port: LinkE  output  32  PCPlus4E for JAL/JALR, else 0.
REQ-012 SHALL have port: TrapE  output  1  sticky misaligned-target trap.
REQ-013 SHALL have port: BranchCountE  output  16  count of redirects taken.

Function
REQ-014 SHALL register InstrD, PCD, PCPlus4D, RD1D, RD2D into E on every rising edge; 1-cycle latency D->E.
REQ-015 SHALL decode in E: opcode 1100011 = branch (funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 = not taken); 1101111 = JAL; 1100111 = JALR; all else = non-control.
REQ-016 SHALL compute immediates: B-type sign-extended {i[31],i[7],i[30:25],i[11:8],0}; J-type sign-extended {i[31],i[19:12],i[20],i[30:21],0}; I-type sign-extended i[31:20].
REQ-017 SHALL form PCTargetE = PCE+immB (branch), PCE+immJ (JAL), (RD1E+immI) with bit0 cleared (JALR), else PCPlus4E; 32-bit wrap, carry discarded.
REQ-018 SHALL drive PCSrcE combinationally = ValidE AND state==RUN AND (taken branch OR JAL OR JALR) AND PCTargetE[1:0]==00.
REQ-019 SHALL run FSM states RUN, FLUSH, HALT: RUN->FLUSH when PCSrcE=1; FLUSH->RUN unconditionally after one cycle; RUN->HALT when redirect would occur but PCTargetE[1:0]!=00; HALT exits only on reset.
REQ-020 SHALL load ValidE=0 on the edge leaving state FLUSH entry (wrong-path instruction squashed; exactly one bubble per redirect), ValidE=1 otherwise in RUN/FLUSH, ValidE=0 in HALT.
REQ-021 SHALL never assert PCSrcE for a squashed (ValidE=0) instruction, including a control instruction immediately following a taken branch.
REQ-022 SHALL set TrapE=1 on entry to HALT and hold it until reset; PCSrcE=0 in HALT.
REQ-023 SHALL increment BranchCountE on each cycle with PCSrcE=1, saturating at 0xFFFF.
REQ-024 SHALL drive LinkE = PCPlus4E when ValidE and (JAL or JALR), else 0.

Reset
REQ-025 SHALL, while rst=0, force: InstrE=0x00000013, PCE=0, PCPlus4E=0, RD1E=RD2E=0, ValidE=0, state=RUN, TrapE=0, BranchCountE=0; hence PCSrcE=0, PCTargetE=0, LinkE=0.
REQ-026 SHALL, on reset asserted mid-FLUSH or in HALT, return to RUN with all above values immediately, no clock needed.
REQ-027 SHALL load first D-stage contents on first rising edge after rst deasserts, ValidE=1.

Structure
REQ-028 SHALL take opcode constants, funct3 codes, NOP encoding and FSM state encoding from shared package riscv_pkg.
REQ-029 SHALL place the six-way compare in sub-module branch_cmp (inputs a, b, funct3; output taken).

Verification
REQ-030 SHALL check reset: rst=0 for 200 time units -> PCSrcE=0, ValidE=0, BranchCountE=0, InstrE=0x00000013.
REQ-031 SHALL check BEQ x1,x2,+16 (InstrD=0x00208863, PCD=0x100, RD1D=RD2D=5) -> next cycle PCSrcE=1, PCTargetE=0x110; following cycle ValidE=0; BranchCountE=1.
REQ-032 SHALL check same BEQ with RD1D=5, RD2D=6 -> PCSrcE=0, PCTargetE=0x104, no bubble.
REQ-033 SHALL check JALR (InstrD=0x004080E7, RD1D=0x201, PCD=0x40) -> PCTargetE=0x204, PCSrcE=1, LinkE=0x44.
REQ-034 SHALL check JAL directly after a taken BLT -> JAL squashed: ValidE=0, PCSrcE=0 in its E cycle, BranchCountE increments once.
REQ-035 SHALL check JALR with RD1D=0x202, immI=0 -> TrapE=1, PCSrcE=0, ValidE=0 held until rst=0.
